// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg
//   Shared definitions for the multicycle MIPS control unit:
//   FSM state codes, instruction opcode/funct fields, ALU control codes,
//   the FSM-to-ALU-decoder operation codes and the datapath mux select codes.
package multicycle_controller_pkg;

  // FSM state codes; these values appear on the State debug port.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Opcode field, Instr[31:26]
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Funct field, Instr[5:0], for the supported R-type operations
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operation requested by the FSM from the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB select codes
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSrc select codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode
//   Combinational ALU control decoder for the multicycle controller.
//   Ports:
//     ALUOp      in  2  operation requested by the FSM (add, sub, or use Funct)
//     Funct      in  6  Instr[5:0]
//     ALUControl out 3  ALU operation code
//     FunctLegal out 1  Funct is one of the supported R-type operations
module mc_alu_decode
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl,
  output logic       FunctLegal
);

  logic [2:0] funct_control;

  // Map the R-type funct field onto an ALU operation and flag unsupported codes.
  always_comb begin
    funct_control = ALU_ADD;
    FunctLegal    = 1'b1;
    case (Funct)
      FN_ADD:  funct_control = ALU_ADD;
      FN_SUB:  funct_control = ALU_SUB;
      FN_AND:  funct_control = ALU_AND;
      FN_OR:   funct_control = ALU_OR;
      FN_SLT:  funct_control = ALU_SLT;
      default: FunctLegal    = 1'b0;
    endcase
  end

  // Select between the fixed add/sub operations and the funct-derived one.
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD:   ALUControl = ALU_ADD;
      ALUOP_SUB:   ALUControl = ALU_SUB;
      ALUOP_FUNCT: ALUControl = funct_control;
      default:     ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM sequencing the multicycle MIPS datapath with a
//   variable-latency unified memory (MemReady handshake).
//   Ports:
//     Clk, Reset         clock; asynchronous active-low reset (forces FETCH)
//     Opcode, Funct      instruction fields from the IR
//     Zero               ALU zero flag (qualifies PCEn in BRANCH)
//     MemReady           memory access completes this cycle
//     IorD..PCSrc        datapath mux selects and write enables
//     PCEn               gated PC load enable
//     InstrRetired       one-cycle pulse on instruction completion
//     Trap               illegal-instruction flag, held until reset
//     State              current state code, for debug
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               InstrRetired,
  output logic               Trap,
  output logic [STATE_W-1:0] State
);

  state_t     state_q;
  state_t     state_d;

  logic [1:0] alu_op;
  logic       alu_used;
  logic [2:0] dec_alu_control;
  logic       funct_legal;

  // Enables before reset gating; they are forced low while Reset is asserted
  // because FETCH would otherwise pass MemReady straight through.
  logic       pc_write;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       retire_raw;
  logic       trap_raw;

  mc_alu_decode u_alu_decode (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUControl (dec_alu_control),
    .FunctLegal (funct_legal)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Moore output decode; everything defaults to 0.
  always_comb begin
    state_d       = state_q;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_B;
    PCSrc         = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    alu_used      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    trap_raw      = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB      = SRCB_FOUR;
        alu_used     = 1'b1;
        ir_write_raw = MemReady;
        pc_write     = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here and parked in ALUOut.
        ALUSrcB  = SRCB_IMM_SH2;
        alu_used = 1'b1;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_legal ? S_EXECUTE : S_TRAP;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        alu_used = 1'b1;
        state_d  = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write request stays up until memory accepts it.
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        if (MemReady) begin
          retire_raw = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ALUSrcA  = 1'b1;
        alu_op   = ALUOP_FUNCT;
        alu_used = 1'b1;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        alu_op     = ALUOP_SUB;
        alu_used   = 1'b1;
        PCSrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        alu_used = 1'b1;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        pc_write   = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        // Only reset leaves this state.
        trap_raw = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // States that do not use the ALU drive a zero ALUControl.
  assign ALUControl   = alu_used ? dec_alu_control : 3'b000;

  assign PCEn         = Reset & (pc_write | (branch & Zero));
  assign IRWrite      = Reset & ir_write_raw;
  assign MemWrite     = Reset & mem_write_raw;
  assign RegWrite     = Reset & reg_write_raw;
  assign InstrRetired = Reset & retire_raw;
  assign Trap         = Reset & trap_raw;
  assign State        = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Self-checking bench for multicycle_controller: reset values, a decode
//   vector table, latency sequence, MemReady stalls, beq, trap, asynchronous
//   reset during a memory write, and randomized instruction streams checked
//   against an instruction-level cycle model.
module tb_multicycle_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn, InstrRetired, Trap;
  logic [3:0] State;

  multicycle_controller #(.STATE_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
    .InstrRetired(InstrRetired), .Trap(Trap), .State(State)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // {PCEn, IRWrite, RegWrite, MemWrite, InstrRetired}
  logic [4:0] en5;
  assign en5 = {PCEn, IRWrite, RegWrite, MemWrite, InstrRetired};

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [3:0] exp_state;
    logic [2:0] exp_alu;
  } dec_vec_t;
  dec_vec_t vecs[12];

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic [4:0] en;
  } exp_cycle_t;
  exp_cycle_t exp_q[$];

  logic [5:0] kind_op[6];
  logic [5:0] legal_fn[5];
  int         lat[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic mr);
    Opcode   = op;
    Funct    = fn;
    Zero     = z;
    MemReady = mr;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge, in the first FETCH cycle.
  task automatic doReset();
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
  endtask

  task automatic push(input logic [3:0] st, input logic mr, input logic [4:0] en);
    exp_cycle_t e;
    e.st = st;
    e.mr = mr;
    e.en = en;
    exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle trace of one instruction given its class and
  // memory wait counts: 0 lw, 1 sw, 2 R-type, 3 addi, 4 beq, 5 j.
  task automatic buildInstr(input int kind, input logic z, input int wf, input int wm);
    repeat (wf) push(4'd0, 1'b0, 5'b00000);
    push(4'd0, 1'b1, 5'b11000);
    push(4'd1, 1'($urandom_range(0, 1)), 5'b00000);
    case (kind)
      0: begin
        push(4'd2, 1'($urandom_range(0, 1)), 5'b00000);
        repeat (wm) push(4'd3, 1'b0, 5'b00000);
        push(4'd3, 1'b1, 5'b00000);
        push(4'd4, 1'($urandom_range(0, 1)), 5'b00101);
      end
      1: begin
        push(4'd2, 1'($urandom_range(0, 1)), 5'b00000);
        repeat (wm) push(4'd5, 1'b0, 5'b00010);
        push(4'd5, 1'b1, 5'b00011);
      end
      2: begin
        push(4'd6, 1'($urandom_range(0, 1)), 5'b00000);
        push(4'd7, 1'($urandom_range(0, 1)), 5'b00101);
      end
      3: begin
        push(4'd9, 1'($urandom_range(0, 1)), 5'b00000);
        push(4'd10, 1'($urandom_range(0, 1)), 5'b00101);
      end
      4: push(4'd8, 1'($urandom_range(0, 1)), {z, 4'b0001});
      default: push(4'd11, 1'($urandom_range(0, 1)), 5'b10001);
    endcase
  endtask

  initial begin
    int ret_cnt;
    int ret_cyc;
    int irw_cnt;
    int irw_cyc;
    int pcen_cnt;
    exp_cycle_t e;

    vecs[0]  = '{6'b100011, 6'b000100, 4'd2,  3'b010};
    vecs[1]  = '{6'b101011, 6'b000000, 4'd2,  3'b010};
    vecs[2]  = '{6'b000000, 6'b100000, 4'd6,  3'b010};
    vecs[3]  = '{6'b000000, 6'b100010, 4'd6,  3'b110};
    vecs[4]  = '{6'b000000, 6'b100100, 4'd6,  3'b000};
    vecs[5]  = '{6'b000000, 6'b100101, 4'd6,  3'b001};
    vecs[6]  = '{6'b000000, 6'b101010, 4'd6,  3'b111};
    vecs[7]  = '{6'b000000, 6'b000000, 4'd12, 3'b000};
    vecs[8]  = '{6'b000100, 6'b000011, 4'd8,  3'b110};
    vecs[9]  = '{6'b001000, 6'b000101, 4'd9,  3'b010};
    vecs[10] = '{6'b000010, 6'b000000, 4'd11, 3'b000};
    vecs[11] = '{6'b111111, 6'b100000, 4'd12, 3'b000};

    kind_op  = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    lat      = '{5, 4, 4, 4, 3, 3};

    // Reset asserted: FETCH with all enables held low even though MemReady=1.
    applyStimulus(6'b100011, 6'b000100, 1'b1, 1'b1);
    #1 Reset = 1'b0;
    #2;
    checkOutput("rst_state", 32'(State), 32'd0);
    checkOutput("rst_enables", 32'({en5, Trap}), 32'd0);
    checkOutput("rst_alusrcb", 32'(ALUSrcB), 32'd1);
    checkOutput("rst_aluctl", 32'(ALUControl), 32'd2);
    checkOutput("rst_iord_srca_pcsrc", 32'({IorD, ALUSrcA, PCSrc}), 32'd0);
    nextCycle();
    checkOutput("rst_hold_enables", 32'({en5, Trap}), 32'd0);

    // Decode table: state and ALUControl in the cycle after DECODE.
    for (int i = 0; i < 12; i++) begin
      doReset();
      applyStimulus(vecs[i].opcode, vecs[i].funct, 1'b0, 1'b1);
      nextCycle();
      nextCycle();
      @(negedge Clk);
      checkOutput($sformatf("vec%0d_state", i), 32'(State), 32'(vecs[i].exp_state));
      checkOutput($sformatf("vec%0d_aluctl", i), 32'(ALUControl), 32'(vecs[i].exp_alu));
      if (vecs[i].exp_state == 4'd12) begin
        for (int c = 0; c < 20; c++) begin
          MemReady = 1'($urandom_range(0, 1));
          Zero     = 1'($urandom_range(0, 1));
          @(negedge Clk);
          checkOutput($sformatf("vec%0d_trap_state_c%0d", i, c), 32'(State), 32'd12);
          checkOutput($sformatf("vec%0d_trap_en_c%0d", i, c), 32'({en5, Trap}), 32'b000001);
        end
      end
    end

    // Latency with MemReady high: lw, sw, add, addi, beq, j.
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(kind_op[k], (k == 2) ? 6'b100000 : 6'b000100, 1'b1, 1'b1);
      ret_cnt = 0;
      ret_cyc = 0;
      for (int c = 1; c <= lat[k]; c++) begin
        @(negedge Clk);
        if (InstrRetired) begin
          ret_cnt++;
          ret_cyc = c;
        end
        nextCycle();
      end
      checkOutput($sformatf("lat%0d_retire_count", k), 32'(ret_cnt), 32'd1);
      checkOutput($sformatf("lat%0d_retire_cycle", k), 32'(ret_cyc), 32'(lat[k]));
    end

    // lw with 3 FETCH stall cycles and 2 MEMREAD stall cycles.
    doReset();
    applyStimulus(6'b100011, 6'b000100, 1'b0, 1'b0);
    ret_cyc  = 0;
    irw_cnt  = 0;
    irw_cyc  = 0;
    pcen_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      MemReady = (c == 4 || c == 9);
      @(negedge Clk);
      if (InstrRetired && ret_cyc == 0) ret_cyc = c;
      if (IRWrite) begin
        irw_cnt++;
        irw_cyc = c;
      end
      if (PCEn) pcen_cnt++;
      nextCycle();
    end
    checkOutput("stall_retire_cycle", 32'(ret_cyc), 32'd10);
    checkOutput("stall_irwrite_count", 32'(irw_cnt), 32'd1);
    checkOutput("stall_irwrite_cycle", 32'(irw_cyc), 32'd4);
    checkOutput("stall_pcen_count", 32'(pcen_cnt), 32'd1);

    // beq taken then not taken.
    doReset();
    applyStimulus(6'b000100, 6'b000011, 1'b1, 1'b1);
    nextCycle();
    nextCycle();
    @(negedge Clk);
    checkOutput("beq_z1_state", 32'(State), 32'd8);
    checkOutput("beq_z1_pcen", 32'(PCEn), 32'd1);
    checkOutput("beq_z1_pcsrc", 32'(PCSrc), 32'd1);
    checkOutput("beq_z1_retired", 32'(InstrRetired), 32'd1);
    nextCycle();
    Zero = 1'b0;
    nextCycle();
    nextCycle();
    @(negedge Clk);
    checkOutput("beq_z0_state", 32'(State), 32'd8);
    checkOutput("beq_z0_pcen", 32'(PCEn), 32'd0);
    checkOutput("beq_z0_retired", 32'(InstrRetired), 32'd1);

    // Asynchronous reset during a pending memory write.
    doReset();
    applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b1);
    nextCycle();
    MemReady = 1'b0;
    nextCycle();
    nextCycle();
    @(negedge Clk);
    checkOutput("memwr_state", 32'(State), 32'd5);
    checkOutput("memwr_memwrite", 32'(MemWrite), 32'd1);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async_rst_memwrite", 32'(MemWrite), 32'd0);
    checkOutput("async_rst_state", 32'(State), 32'd0);
    checkOutput("async_rst_enables", 32'({en5, Trap}), 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      checkOutput($sformatf("post_rst_regwrite_c%0d", c), 32'(RegWrite), 32'd0);
      checkOutput($sformatf("post_rst_state_c%0d", c), 32'(State), 32'd0);
      nextCycle();
    end

    // Randomized instruction stream against the cycle-trace model.
    doReset();
    for (int n = 0; n < 60; n++) begin
      int   kind;
      logic z;
      kind = $urandom_range(0, 5);
      z    = 1'($urandom_range(0, 1));
      applyStimulus(kind_op[kind],
                    (kind == 2) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom),
                    z, 1'b0);
      buildInstr(kind, z, $urandom_range(0, 3), $urandom_range(0, 3));
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        MemReady = e.mr;
        @(negedge Clk);
        checkOutput($sformatf("rnd%0d_state", n), 32'(State), 32'(e.st));
        checkOutput($sformatf("rnd%0d_enables", n), 32'(en5), 32'(e.en));
        nextCycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
